// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand-select codes,
// default "writes a register" control code and the stage control type.
package fwd_pkg;

    localparam int CTRL_W_DEF = 4;
    localparam logic [CTRL_W_DEF-1:0] WR_CODE_DEF = 4'h0;

    typedef logic [CTRL_W_DEF-1:0] ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_MW = 2'b01,
        FWD_EM = 2'b10
    } fwd_sel_t;

    // The younger producer (EX/MEM) holds the newer value, so it wins over MEM/WB.
    function automatic fwd_sel_t fwd_pick(input logic em_hit, input logic mw_hit);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (em_hit) begin
            sel = FWD_EM;
        end else if (mw_hit) begin
            sel = FWD_MW;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_mul_scoreboard.sv
// Tracks the single in-flight multiply: its destination register and the
// cycles remaining until its result can be forwarded.
module mul_scoreboard
    import fwd_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int MUL_LAT  = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              flush,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    output logic              busy,
    output logic              match
);

    logic [ADDR_W-1:0] sb_rd;
    logic [3:0]        sb_cnt;

    function automatic logic reg_hit(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] r);
        return (rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    assign busy  = (sb_cnt != 4'd0);
    assign match = busy && (reg_hit(sb_rd, id_rs) || reg_hit(sb_rd, id_rt));

    // A flushed multiply is squashed downstream, so only the count needs clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_cnt <= 4'd0;
            sb_rd  <= '0;
        end else if (flush) begin
            sb_cnt <= 4'd0;
        end else if (issue) begin
            sb_cnt <= 4'(MUL_LAT);
            sb_rd  <= issue_rd;
        end else if (busy) begin
            sb_cnt <= sb_cnt - 4'd1;
        end
    end

    a_issue_when_idle: assert property (@(posedge clk) disable iff (!rst_n) issue |-> !busy);

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand bypass selection plus decode stall generation for load-use
// hazards and the multi-cycle multiplier.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] WR_CODE  = CTRL_W'(WR_CODE_DEF),
    parameter int                MUL_LAT  = 3,
    parameter int                ZERO_REG = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_is_mul,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] em_rd,
    input  logic [ADDR_W-1:0] mw_rd,
    input  logic [CTRL_W-1:0] em_ctrl,
    input  logic [CTRL_W-1:0] mw_ctrl,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic em_wr, mw_wr;
    logic load_use, raw_mul, struct_mul;
    logic sb_busy, sb_match, issue;

    function automatic logic reg_hit(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] r);
        return (rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    assign em_wr = (em_ctrl == WR_CODE);
    assign mw_wr = (mw_ctrl == WR_CODE);

    assign fwd_a = fwd_pick(em_wr && reg_hit(em_rd, ex_rs), mw_wr && reg_hit(mw_rd, ex_rs));
    assign fwd_b = fwd_pick(em_wr && reg_hit(em_rd, ex_rt), mw_wr && reg_hit(mw_rd, ex_rt));

    assign load_use   = ex_is_load && id_valid && (reg_hit(ex_rd, id_rs) || reg_hit(ex_rd, id_rt));
    assign raw_mul    = id_valid && sb_match;
    assign struct_mul = id_valid && id_is_mul && sb_busy;

    // Flush discards whatever sits in decode, so a stall would only hold a dead instruction.
    assign stall = (load_use || raw_mul || struct_mul) && !flush;
    assign issue = id_valid && id_is_mul && !stall && !flush;

    mul_scoreboard #(
        .ADDR_W  (ADDR_W),
        .MUL_LAT (MUL_LAT),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .issue   (issue),
        .flush   (flush),
        .issue_rd(id_rd),
        .id_rs   (id_rs),
        .id_rt   (id_rt),
        .busy    (sb_busy),
        .match   (sb_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    a_fwd_a_legal: assert property (@(posedge clk) disable iff (!rst_n) fwd_a != 2'b11);
    a_fwd_b_legal: assert property (@(posedge clk) disable iff (!rst_n) fwd_b != 2'b11);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench for fwd_hazard_unit: a reference model predicts outputs
// each cycle, expectations are queued on drive and popped at the sample point.
module tb_fwd_hazard_unit;

  localparam int ADDR_W   = 4;
  localparam int CTRL_W   = 4;
  localparam int MUL_LAT  = 3;
  localparam int ZERO_REG = 1;
  localparam int CNT_W    = 4;
  localparam int EW       = 5 + CNT_W;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic              id_is_mul;
  logic [ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic              ex_is_load;
  logic [ADDR_W-1:0] em_rd, mw_rd;
  logic [CTRL_W-1:0] em_ctrl, mw_ctrl;
  logic              flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]        m_cnt;
  logic [ADDR_W-1:0] m_rd;
  logic [CNT_W-1:0]  m_scnt;
  logic [CNT_W-1:0]  base;

  fwd_hazard_unit #(
    .ADDR_W  (ADDR_W),
    .CTRL_W  (CTRL_W),
    .WR_CODE (4'h0),
    .MUL_LAT (MUL_LAT),
    .ZERO_REG(ZERO_REG),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .id_is_mul (id_is_mul),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_rd     (ex_rd),
    .ex_is_load(ex_is_load),
    .em_rd     (em_rd),
    .mw_rd     (mw_rd),
    .em_ctrl   (em_ctrl),
    .mw_ctrl   (mw_ctrl),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] r);
    return (rd == r) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  function automatic logic [1:0] model_sel(input logic [ADDR_W-1:0] r);
    if (em_ctrl == 4'h0 && hit(em_rd, r)) return 2'b10;
    if (mw_ctrl == 4'h0 && hit(mw_rd, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall();
    logic lu, raw, str;
    lu  = ex_is_load && id_valid && (hit(ex_rd, id_rs) || hit(ex_rd, id_rt));
    raw = id_valid && (m_cnt != 0) && (hit(m_rd, id_rs) || hit(m_rd, id_rt));
    str = id_valid && id_is_mul && (m_cnt != 0);
    return (lu || raw || str) && !flush;
  endfunction

  // driver: inputs already set; queue the prediction, sample, then advance the model
  task automatic cycle();
    logic [EW-1:0] e, g;
    logic st, iss;
    st  = model_stall();
    iss = id_valid && id_is_mul && !st && !flush;
    exp_q.push_back({model_sel(ex_rs), model_sel(ex_rt), st, m_scnt});
    @(negedge clk);
    g = {fwd_a, fwd_b, stall, stall_cnt};
    e = exp_q.pop_front();
    check("fwd_a", 32'(g[EW-1 -: 2]), 32'(e[EW-1 -: 2]));
    check("fwd_b", 32'(g[EW-3 -: 2]), 32'(e[EW-3 -: 2]));
    check("stall", 32'(g[CNT_W]), 32'(e[CNT_W]));
    check("stall_cnt", 32'(g[CNT_W-1:0]), 32'(e[CNT_W-1:0]));
    @(posedge clk);
    if (flush) m_cnt = 4'd0;
    else if (iss) begin
      m_cnt = 4'(MUL_LAT);
      m_rd  = id_rd;
    end else if (m_cnt != 0) m_cnt = m_cnt - 4'd1;
    if (st && m_scnt != '1) m_scnt = m_scnt + 1'b1;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_is_mul = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_is_load = 0;
    em_rd = 0; mw_rd = 0; em_ctrl = 4'hF; mw_ctrl = 4'hF; flush = 0;
  endtask

  task automatic issue_mul(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs,
                           input logic [ADDR_W-1:0] rt);
    idle();
    id_valid = 1; id_is_mul = 1; id_rd = rd; id_rs = rs; id_rt = rt;
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_cnt = 0; m_rd = 0; m_scnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    cycle();

    // EX/MEM priority over MEM/WB
    idle(); em_rd = 5; em_ctrl = 0; mw_rd = 5; mw_ctrl = 0; ex_rs = 5; ex_rt = 5;
    cycle();
    check("fwd_em_prio", 32'(fwd_a), 32'(2'b10));

    // MEM/WB only, EX/MEM ctrl not a write
    idle(); mw_rd = 3; mw_ctrl = 0; em_rd = 3; em_ctrl = 4'h2; ex_rt = 3; ex_rs = 4;
    cycle();
    check("fwd_b_mw", 32'(fwd_b), 32'(2'b01));

    // register 0 never forwards
    idle(); mw_rd = 0; mw_ctrl = 0; em_rd = 0; em_ctrl = 0; ex_rs = 0; ex_rt = 0;
    cycle();
    check("fwd_zero", 32'({fwd_a, fwd_b}), 32'(4'b0000));

    // load-use on rs, then bubble releases
    idle(); ex_is_load = 1; ex_rd = 7; id_valid = 1; id_rs = 7; base = m_scnt;
    cycle();
    check("lu_cnt", 32'(stall_cnt), 32'(CNT_W'(base + 1)));
    ex_is_load = 0;
    cycle();
    // load-use on rt
    idle(); ex_is_load = 1; ex_rd = 6; id_valid = 1; id_rs = 1; id_rt = 6;
    cycle();
    ex_is_load = 0;
    cycle();

    // RAW on multiply destination: three stalled cycles
    issue_mul(9, 1, 2); base = m_scnt;
    cycle();
    id_is_mul = 0; id_rs = 9;
    repeat (4) cycle();
    check("mul_raw_cnt", 32'(stall_cnt), 32'(CNT_W'(base + 3)));

    // structural: second multiply waits for the first
    issue_mul(10, 1, 2);
    cycle();
    id_rd = 11; id_rs = 3; id_rt = 4;
    repeat (4) cycle();
    idle();
    repeat (4) cycle();

    // flush while a multiply is in flight
    issue_mul(12, 1, 2);
    cycle();
    id_is_mul = 0; id_rs = 12;
    repeat (2) cycle();
    flush = 1; base = m_scnt;
    cycle();
    check("flush_no_cnt", 32'(stall_cnt), 32'(base));
    flush = 0;
    cycle();
    check("flush_release", 32'(stall), 32'(0));

    // asynchronous reset mid-scoreboard
    issue_mul(13, 1, 2);
    cycle();
    id_is_mul = 0; id_rs = 13;
    cycle();
    check("pre_rst_stall", 32'(stall), 32'(1));
    rst_n = 0;
    #1;
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_cnt", 32'(stall_cnt), 32'(0));
    m_cnt = 0; m_rd = 0; m_scnt = 0;
    #1 rst_n = 1;
    cycle();

    // stall counter saturation
    idle(); ex_is_load = 1; ex_rd = 6; id_valid = 1; id_rt = 6;
    repeat (20) cycle();
    check("sat_cnt", 32'(stall_cnt), 32'({CNT_W{1'b1}}));

    // random traffic over a small register range
    repeat (250) begin
      id_valid   = 1'($urandom_range(0, 3) != 0);
      id_rs      = 4'($urandom_range(0, 3));
      id_rt      = 4'($urandom_range(0, 3));
      id_rd      = 4'($urandom_range(0, 3));
      id_is_mul  = 1'($urandom_range(0, 3) == 0);
      ex_rs      = 4'($urandom_range(0, 3));
      ex_rt      = 4'($urandom_range(0, 3));
      ex_rd      = 4'($urandom_range(0, 3));
      ex_is_load = 1'($urandom_range(0, 3) == 0);
      em_rd      = 4'($urandom_range(0, 3));
      mw_rd      = 4'($urandom_range(0, 3));
      em_ctrl    = 4'($urandom_range(0, 2));
      mw_ctrl    = 4'($urandom_range(0, 2));
      flush      = 1'($urandom_range(0, 15) == 0);
      cycle();
    end

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined datapath. It selects operand-bypass sources for the EX stage, giving EX/MEM priority over MEM/WB. It also generates decode-stage stalls for load-use hazards and for a multi-cycle multiplier tracked by an internal scoreboard. It sits beside the ID/EX pipeline register and drives the EX operand muxes, the PC/IF-ID hold and the ID/EX bubble insertion.

## Interface
- ADDR_W, 4, register address width
- CTRL_W, 4, width of stage control codes
- WR_CODE, 4'h0, control code meaning "stage writes a register"
- MUL_LAT, 3, multiplier latency in cycles (1..15)
- ZERO_REG, 1, when 1 register 0 is hardwired and never matches
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rs, id_rt  in  ADDR_W  decode source registers
- id_rd  in  ADDR_W  decode destination
- id_is_mul  in  1  decode instruction is a multiply
- ex_rs, ex_rt  in  ADDR_W  EX-stage source registers
- ex_rd  in  ADDR_W  EX-stage destination
- ex_is_load  in  1  EX-stage instruction is a load
- em_rd, mw_rd  in  ADDR_W  EX/MEM and MEM/WB destinations
- em_ctrl, mw_ctrl  in  CTRL_W  EX/MEM and MEM/WB control codes
- flush  in  1  pipeline flush, synchronous
- fwd_a, fwd_b  out  2  operand select for rs/rt: 00 register file, 01 MEM/WB, 10 EX/MEM
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- A stage "writes r" when its ctrl == WR_CODE and its rd == r. If ZERO_REG = 1, r = 0 never matches anything.
- fwd_a: 10 if EX/MEM writes ex_rs, else 01 if MEM/WB writes ex_rs, else 00. fwd_b follows the same rule with ex_rt. EX/MEM wins when both stages match.
- load_use: ex_is_load and id_valid and ex_rd equals id_rs or id_rt.
- Scoreboard holds sb_rd (ADDR_W) and sb_cnt (4 bits). busy = (sb_cnt != 0).
- raw_mul: id_valid, busy, and sb_rd equals id_rs or id_rt.
- struct_mul: id_valid, id_is_mul and busy.
- stall = load_use | raw_mul | struct_mul. It is forced to 0 while flush = 1.
- Issue occurs when id_valid, id_is_mul, !stall and !flush. On issue: sb_cnt <= MUL_LAT, sb_rd <= id_rd. Otherwise sb_cnt decrements while nonzero.
- Issue and decrement are never simultaneous, because issue requires !busy.
- flush: sb_cnt <= 0 on the next edge, and the multiplier result is squashed by the pipeline.
- stall_cnt increments on each edge where stall = 1 and saturates at all-ones.

## Timing
- fwd_a, fwd_b and stall are combinational from the current inputs plus scoreboard state. There is no added latency.
- Reset (rst_n low, asynchronous): sb_cnt = 0, sb_rd = 0, stall_cnt = 0. Outputs are therefore fwd_a = fwd_b = 00 with no writers, stall = 0 with id_valid = 0.
- A multiply issued in cycle t gives sb_cnt = MUL_LAT at t+1 and 1 at t+MUL_LAT. A dependent instruction in decode is released in cycle t+MUL_LAT+1 and obtains its operand by normal forwarding.
- A load-use stall lasts exactly one cycle, because the bubble clears ex_is_load.
- Reset asserted mid-scoreboard clears busy immediately, since it is asynchronous. stall drops in the same cycle.
- flush and stall in the same cycle: flush wins, stall = 0, and stall_cnt does not increment.

## Structure
- Package fwd_pkg holds:
  - FWD_RF = 2'b00, FWD_MW = 2'b01, FWD_EM = 2'b10
  - WR_CODE default
  - a ctrl_t typedef of width CTRL_W
- Sub-module mul_scoreboard (sb_rd, sb_cnt, issue/flush logic, busy and match outputs). The forward compare and stall OR stay in the top module.

## Test plan
- em: rd = 5, ctrl = 0; mw: rd = 5, ctrl = 0; ex_rs = 5, ex_rt = 5 -> fwd_a = fwd_b = 10 (EX/MEM priority).
- mw: rd = 3, ctrl = 0; em_ctrl = 4'h2; ex_rt = 3 -> fwd_b = 01, fwd_a = 00. Repeat with rd = 0 and ZERO_REG = 1 -> both 00.
- ex_is_load = 1, ex_rd = 7, id_valid = 1, id_rs = 7 -> stall = 1 for one cycle, stall_cnt 0 -> 1. Bubble drives ex_is_load = 0 -> stall = 0.
- MUL_LAT = 3, issue mul with rd = 9 at t. Next instruction reads r9 -> stall high for t+1..t+3, low at t+4, stall_cnt = 3. A second mul decoded at t+1 stalls over the same cycles.
- Mul in flight (sb_cnt = 2); assert flush -> stall = 0 that cycle, sb_cnt = 0 next edge, dependent read proceeds.
- Mul in flight; pulse rst_n low between edges -> stall and busy drop immediately, stall_cnt = 0.
